// File: rtl/puf_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : puf_spi_pkg
// Brief   : Shared constants, state encoding and width helpers for the PUF
//           response SPI transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package puf_spi_pkg;

  // Default response width and the status header that precedes it
  localparam int DEF_DATA_W = 128;
  localparam int HDR_W      = 8;
  localparam int DEF_FRAME_W = DEF_DATA_W + HDR_W;
  localparam int DEF_CNT_W   = $clog2(DEF_FRAME_W + 1);

  // Fixed pattern in header bits 5:0 so the master can recognise a frame
  localparam logic [5:0] DEF_HDR_MARK = 6'b101010;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Frame length for a given response width
  function automatic int frame_w(input int data_w);
    return data_w + HDR_W;
  endfunction

  // Bit counter width: must hold the saturated value frame_w itself
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + HDR_W + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_resp_spi_tx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : sync_edge
// Brief   : Multi-flop synchroniser for an asynchronous pad input, followed
//           by one history register that yields single-cycle rise/fall pulses.
// Revision: 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int   SYNC_STAGES = 2,     // at least 2 for metastability margin
  parameter logic IDLE_VAL    = 1'b0   // value the line rests at when idle
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus edge-history flop; reset to the idle level so
  // no spurious edge comes out of reset while the pad is idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/puf_resp_spi_tx.sv
`default_nettype none
// ============================================================================
// Module  : puf_resp_spi_tx
// Brief   : Captures the PUF response on the rising edge of DONE and serves it
//           to an external SPI master (slave, mode 0, MSB first) behind an
//           8-bit status header {VALID, OVERRUN, HDR_MARK}. SPI pads are
//           oversampled in the CLK domain.
// Revision: 1.0 - initial release
// ============================================================================
module puf_resp_spi_tx
  import puf_spi_pkg::*;
#(
  parameter int         DATA_W      = DEF_DATA_W,
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] HDR_MARK    = DEF_HDR_MARK
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DONE,
  input  logic [DATA_W-1:0] PUF_OUT_REG,
  input  logic              SCLK,
  input  logic              CS_N,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              VALID,
  output logic              OVERRUN
);

  localparam int FRAME_BITS = frame_w(DATA_W);
  localparam int CNT_BITS   = cnt_w(DATA_W);
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(FRAME_BITS - 1);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(FRAME_BITS);

  // Synchronised pad views
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_sclk;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_VAL    (1'b0)
  ) u_sync_sclk (
    .clk   (CLK),
    .rst_n (RESET),
    .din   (SCLK),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_VAL    (1'b1)
  ) u_sync_cs (
    .clk   (CLK),
    .rst_n (RESET),
    .din   (CS_N),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Mode 0 only needs the falling SCLK edge to launch data
  assign unused_sclk = sclk_level | sclk_rise;

  // Registered state
  state_t                  state_q, state_d;
  logic                    done_q;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;
  logic                    snap_ovr_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [CNT_BITS-1:0]     cnt_q;
  logic                    miso_q;

  // Control strobes from the FSM
  logic load, shift, complete;
  logic done_rise;

  assign done_rise = DONE & ~done_q;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and control strobes; cs_rise takes priority over a
  // coincident sclk_fall because the frame is over either way
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d  = IDLE;
          complete = (cnt_q >= LAST_IDX);
        end else if (sclk_fall) begin
          shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status and shadow next values. A completed read clears VALID and only
  // the OVERRUN that the master actually saw in the header; an overrun that
  // happened during this frame stays flagged for the next one. A DONE edge
  // coinciding with completion is treated as arriving just after it.
  always_comb begin
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    shadow_d = shadow_q;
    if (complete) begin
      valid_d = 1'b0;
      ovr_d   = ovr_q & ~snap_ovr_q;
    end
    if (done_rise) begin
      if (state_q == IDLE) begin
        shadow_d = PUF_OUT_REG;
        if (valid_q) ovr_d   = 1'b1;
        else         valid_d = 1'b1;
      end else if (complete) begin
        shadow_d = PUF_OUT_REG;
        valid_d  = 1'b1;
      end else begin
        // Frame in flight: keep the shadow intact, drop the new data
        ovr_d = 1'b1;
      end
    end
  end

  // Datapath: shadow/status registers, frame shifter, bit counter, MISO
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      done_q     <= 1'b0;
      shadow_q   <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      snap_ovr_q <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
    end else begin
      done_q   <= DONE;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      if (load) begin
        shreg_q    <= {valid_d, ovr_d, HDR_MARK, shadow_d};
        miso_q     <= valid_d;
        cnt_q      <= '0;
        snap_ovr_q <= ovr_d;
      end else if (shift) begin
        shreg_q <= shreg_q << 1;
        miso_q  <= shreg_q[FRAME_BITS-2];
        if (cnt_q != FULL_CNT) cnt_q <= cnt_q + CNT_BITS'(1);
      end else if (state_q == SHIFT && cs_rise) begin
        miso_q <= 1'b0;
      end
    end
  end

  assign MISO    = miso_q;
  assign MISO_OE = ~cs_level;
  assign VALID   = valid_q;
  assign OVERRUN = ovr_q;

endmodule
`default_nettype wire
